// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared timing presets and helper functions for the VGA timing generator.
//   calc_total : pixels (or lines) per period from active/front porch/sync/back porch
//   calc_cw    : minimum counter width able to hold total-1
package vga_timing_pkg;

  function automatic int unsigned calc_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned calc_cw(input int unsigned total);
    return (total <= 1) ? 1 : $clog2(total);
  endfunction

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock, negative syncs
  localparam int unsigned VGA640_H_ACTIVE = 640;
  localparam int unsigned VGA640_H_FP     = 16;
  localparam int unsigned VGA640_H_SYNC   = 96;
  localparam int unsigned VGA640_H_BP     = 48;
  localparam int unsigned VGA640_V_ACTIVE = 480;
  localparam int unsigned VGA640_V_FP     = 10;
  localparam int unsigned VGA640_V_SYNC   = 2;
  localparam int unsigned VGA640_V_BP     = 33;
  localparam bit          VGA640_H_POL    = 1'b0;
  localparam bit          VGA640_V_POL    = 1'b0;

  // 800x600 @ 72 Hz, 50 MHz pixel clock, positive syncs
  localparam int unsigned SVGA800_H_ACTIVE = 800;
  localparam int unsigned SVGA800_H_FP     = 56;
  localparam int unsigned SVGA800_H_SYNC   = 120;
  localparam int unsigned SVGA800_H_BP     = 64;
  localparam int unsigned SVGA800_V_ACTIVE = 600;
  localparam int unsigned SVGA800_V_FP     = 37;
  localparam int unsigned SVGA800_V_SYNC   = 6;
  localparam int unsigned SVGA800_V_BP     = 23;
  localparam bit          SVGA800_H_POL    = 1'b1;
  localparam bit          SVGA800_V_POL    = 1'b1;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis (horizontal or vertical) of the VGA generator.
// Counts 0..TOTAL-1 on each step and decodes the current count combinationally.
// Ports:
//   px_clk, reset_n : pixel clock, asynchronous active-low reset
//   step            : advance the counter on this edge
//   count           : current position
//   last            : count == TOTAL-1
//   sync_d          : sync level for the current count (POL while in the sync pulse)
//   blank_d         : count < FP+SYNC+BP
//   active_d        : count in the visible part of the axis
//   pos_d           : count-BLANK while active, else 0
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BP     = 48,
  parameter bit          POL    = 1'b0,
  parameter int unsigned CW     = 10
) (
  input  logic          px_clk,
  input  logic          reset_n,
  input  logic          step,
  output logic [CW-1:0] count,
  output logic          last,
  output logic          sync_d,
  output logic          blank_d,
  output logic          active_d,
  output logic [CW-1:0] pos_d
);

  localparam int unsigned   TOTAL   = calc_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CW-1:0] LAST_C  = CW'(TOTAL - 1);
  localparam logic [CW-1:0] FP_C    = CW'(FP);
  localparam logic [CW-1:0] SYNC_C  = CW'(SYNC);
  localparam logic [CW-1:0] BLANK_C = CW'(FP + SYNC + BP);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (step) count_d = last ? '0 : count_q + CW'(1);
  end

  always_ff @(posedge px_clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  always_comb begin
    count    = count_q;
    last     = (count_q == LAST_C);
    // Below FP the subtraction wraps to >= 2^CW-FP, which is never < SYNC
    // because FP+SYNC <= TOTAL-1 < 2^CW; one compare covers the whole window.
    sync_d   = ((count_q - FP_C) < SYNC_C) ? POL : ~POL;
    blank_d  = (count_q < BLANK_C);
    active_d = ~blank_d;
    pos_d    = active_d ? (count_q - BLANK_C) : '0;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA sync/timing generator with pixel enable.
// All outputs are registered and show the decode of the counter state one enabled edge earlier.
// Ports:
//   px_clk, reset_n : pixel clock, asynchronous active-low reset
//   en              : pixel enable; state and outputs advance only when 1
//   hsync, vsync    : sync pulses, asserted level H_POL / V_POL
//   activevideo     : visible region
//   hblank, vblank  : horizontal / vertical blanking
//   x_px, y_px      : position in the visible region, 0 outside it
//   line_start      : one-clock strobe on the cycle showing hc=0
//   frame_start     : one-clock strobe on the cycle showing hc=0, vc=0
//   frame_count     : completed frames, wrapping
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CW       = 10,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned FRAME_CW = 16
) (
  input  logic                px_clk,
  input  logic                reset_n,
  input  logic                en,
  output logic                hsync,
  output logic                vsync,
  output logic                activevideo,
  output logic                hblank,
  output logic                vblank,
  output logic [CW-1:0]       x_px,
  output logic [CW-1:0]       y_px,
  output logic                line_start,
  output logic                frame_start,
  output logic [FRAME_CW-1:0] frame_count
);

  localparam int unsigned H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (CW < calc_cw(H_TOTAL) || CW < calc_cw(V_TOTAL)) begin : g_bad_cw
    $error("vga_timing_gen: CW too small for H_TOTAL/V_TOTAL");
  end
  if (H_SYNC == 0 || V_SYNC == 0) begin : g_bad_sync
    $error("vga_timing_gen: sync length must be non-zero");
  end
  if (H_ACTIVE == 0 || V_ACTIVE == 0) begin : g_bad_active
    $error("vga_timing_gen: active region must be non-zero");
  end

  logic [CW-1:0] h_count, v_count, h_pos, v_pos;
  logic          h_last, v_last, h_sync, v_sync, h_blank, v_blank, h_active, v_active;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL), .CW(CW)
  ) u_h (
    .px_clk(px_clk), .reset_n(reset_n), .step(en),
    .count(h_count), .last(h_last), .sync_d(h_sync), .blank_d(h_blank),
    .active_d(h_active), .pos_d(h_pos)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL), .CW(CW)
  ) u_v (
    .px_clk(px_clk), .reset_n(reset_n), .step(en && h_last),
    .count(v_count), .last(v_last), .sync_d(v_sync), .blank_d(v_blank),
    .active_d(v_active), .pos_d(v_pos)
  );

  logic                hsync_q, hsync_d, vsync_q, vsync_d;
  logic                active_q, active_d, hblank_q, hblank_d, vblank_q, vblank_d;
  logic [CW-1:0]       x_px_q, x_px_d, y_px_q, y_px_d;
  logic                line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic [FRAME_CW-1:0] frame_count_q, frame_count_d;

  always_comb begin
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    active_d      = active_q;
    hblank_d      = hblank_q;
    vblank_d      = vblank_q;
    x_px_d        = x_px_q;
    y_px_d        = y_px_q;
    line_start_d  = en && (h_count == '0);
    frame_start_d = en && (h_count == '0) && (v_count == '0);
    frame_count_d = frame_count_q + FRAME_CW'(en && h_last && v_last);
    if (en) begin
      hsync_d  = h_sync;
      vsync_d  = v_sync;
      active_d = h_active && v_active;
      hblank_d = h_blank;
      vblank_d = v_blank;
      // Each axis only zeroes its own position; both need the combined gate.
      x_px_d   = (h_active && v_active) ? h_pos : '0;
      y_px_d   = (h_active && v_active) ? v_pos : '0;
    end
  end

  always_ff @(posedge px_clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      active_q      <= 1'b0;
      hblank_q      <= 1'b0;
      vblank_q      <= 1'b0;
      x_px_q        <= '0;
      y_px_q        <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      x_px_q        <= x_px_d;
      y_px_q        <= y_px_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  always_comb begin
    hsync       = hsync_q;
    vsync       = vsync_q;
    activevideo = active_q;
    hblank      = hblank_q;
    vblank      = vblank_q;
    x_px        = x_px_q;
    y_px        = y_px_q;
    line_start  = line_start_q;
    frame_start = frame_start_q;
    frame_count = frame_count_q;
  end

endmodule
